// File: rtl/spi_master_mc_if.sv
// spi_master_mc_if
//   Bundles the word-side handshake and the SPI pins of spi_master_mc.
//   Parameters: DATA_W (bits per word), NUM_SS (number of slave selects).
//   Word side  : tx_valid, tx_ready, tx_data, tx_ss, mode, rx_valid, rx_data, busy
//   SPI pins   : spi_sck, mosi, miso, ssel_n
//   Debug      : state_dbg (current FSM state of the master)
//   Optional   : lsb_first, present only when SPI_MASTER_LSB_FIRST_EN is defined.
//   Modports   : master (the SPI master itself), slave (requester / pin side).
interface spi_master_mc_if #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4
);
    localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [SS_W-1:0]   tx_ss;
    logic [1:0]        mode;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              spi_sck;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ssel_n;
    logic [1:0]        state_dbg;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic              lsb_first;
`endif

    modport master (
        input  tx_valid, tx_data, tx_ss, mode, miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
        input  lsb_first,
`endif
        output tx_ready, rx_valid, rx_data, busy, spi_sck, mosi, ssel_n, state_dbg
    );

    modport slave (
        output tx_valid, tx_data, tx_ss, mode, miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
        output lsb_first,
`endif
        input  tx_ready, rx_valid, rx_data, busy, spi_sck, mosi, ssel_n, state_dbg
    );
endinterface

// File: rtl/spi_master_mc.sv
// spi_master_mc
//   Multi-mode (CPOL/CPHA) SPI master. Sends one DATA_W-bit word on mosi while
//   capturing miso, with spi_sck derived from sclk by CLK_DIV cycles per
//   half-period. Sequence per word: SETUP, 2*DATA_W half-periods of XFER, HOLD,
//   each step CLK_DIV cycles long; rx_valid pulses on the cycle the FSM is back
//   in IDLE.
//   Ports: sclk (system clock, rising edge), rst (async, active high),
//          bus (spi_master_mc_if.master: word handshake, SPI pins, state_dbg).
//   Handshake: a word is accepted on the rising sclk edge where tx_valid and
//          tx_ready are both high; tx_ready is high only in IDLE, and tx_data,
//          tx_ss, mode (and lsb_first) are latched on that edge only.
//          rx_valid is a one-cycle pulse with no back-pressure; rx_data holds.
//   Optional: define SPI_MASTER_LSB_FIRST_EN to add bus.lsb_first (LSB-first
//          shifting when 1, latched at accept). Undefined: always MSB first.
module spi_master_mc #(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 4,
    parameter int CLK_DIV = 4
) (
    input logic             sclk,
    input logic             rst,
    spi_master_mc_if.master bus
);
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int HP_N  = 2 * DATA_W;
    localparam int HP_W  = $clog2(HP_N);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [HP_W-1:0]   hp_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
    logic              cpha_q, sck_q, mosi_q, rx_valid_q;
    logic [NUM_SS-1:0] ssel_q, ssel_dec;
    logic              lsb_q, lsb_in;
    logic              div_end, last_hp, toggle, lead, sample_en, drive_en, accept, done;
    logic              head, head_next, first_bit;
    logic [DATA_W-1:0] tx_next, rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
    assign lsb_q  = 1'b0;
`endif

    // Shift direction depends on bit order; head is the bit currently on the wire side.
    assign head      = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    assign head_next = lsb_q ? tx_sh_q[1] : tx_sh_q[DATA_W-2];
    assign tx_next   = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    assign rx_next   = lsb_q ? {bus.miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], bus.miso};
    assign first_bit = lsb_in ? bus.tx_data[0] : bus.tx_data[DATA_W-1];

    assign accept = (state_q == IDLE) && bus.tx_valid;
    assign done   = (state_q == HOLD) && div_end;

    // Selected line goes low; an out-of-range index leaves every select high.
    always_comb begin
        ssel_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (bus.tx_ss == SS_W'(i)) ssel_dec[i] = 1'b0;
        end
    end

    // Next state plus the sck edge strobes. toggle marks the sclk edge that
    // starts a new half-period; lead says whether that edge is a bit's first toggle.
    always_comb begin
        state_d = state_q;
        div_end = (div_q == DIV_W'(CLK_DIV - 1));
        last_hp = (hp_q == HP_W'(HP_N - 1));
        toggle  = 1'b0;
        lead    = 1'b0;
        case (state_q)
            IDLE:  if (bus.tx_valid) state_d = SETUP;
            SETUP: if (div_end) begin
                       state_d = XFER;
                       toggle  = 1'b1;
                       lead    = 1'b1;
                   end
            XFER:  if (div_end) begin
                       if (last_hp) begin
                           state_d = HOLD;
                       end else begin
                           toggle = 1'b1;
                           lead   = hp_q[0];  // entering an even half-period
                       end
                   end
            HOLD:  if (div_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // CPHA=0 samples on leading, drives on trailing; CPHA=1 the reverse.
        sample_en = toggle && (lead != cpha_q);
        drive_en  = toggle && (lead == cpha_q);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            hp_q       <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cpha_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ssel_q     <= '1;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= 1'b0;
            div_q      <= (state_q == IDLE || div_end) ? '0 : div_q + 1'b1;
            if (accept) begin
                tx_sh_q <= bus.tx_data;
                cpha_q  <= bus.mode[0];
                sck_q   <= bus.mode[1];
                hp_q    <= '0;
                ssel_q  <= ssel_dec;
                if (!bus.mode[0]) mosi_q <= first_bit;
            end
            if (toggle) begin
                sck_q <= ~sck_q;
                if (state_q == XFER) hp_q <= hp_q + 1'b1;
            end
            if (drive_en) begin
                mosi_q  <= cpha_q ? head : head_next;
                tx_sh_q <= tx_next;
            end
            if (sample_en) rx_sh_q <= rx_next;
            if (done) begin
                ssel_q     <= '1;
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_sh_q;
            end
        end
    end

`ifdef SPI_MASTER_LSB_FIRST_EN
    always_ff @(posedge sclk or posedge rst) begin
        if (rst)         lsb_q <= 1'b0;
        else if (accept) lsb_q <= lsb_in;
    end
`endif

    assign bus.tx_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.spi_sck   = sck_q;
    assign bus.mosi      = mosi_q;
    assign bus.ssel_n    = ssel_q;
    assign bus.state_dbg = state_q;
endmodule
